huffman_canon: RTL and testbench
================================

HUFFMAN_CANON -- requirements
Module: huffman_canon

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: symbol index width; DATA_SIZE = 2^DATA_WIDTH symbols.
REQ-002 SHALL have parameter FREQ_WIDTH, default 8: frequency field width in each input record.
REQ-003 SHALL have parameter MAX_LEN, default 16: maximum supported code length; also the codeword width.
REQ-004 SHALL derive NUM_WIDTH = DATA_WIDTH+1, LEN_WIDTH = NUM_WIDTH, REC_W = NUM_WIDTH+FREQ_WIDTH+LEN_WIDTH.
REQ-005 clk  input  1  sole clock, rising edge; one clock only.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 sym_start_i  input  1  marks the first record of a code-length stream.
REQ-008 sym_end_i  input  1  marks the last record of the stream.
REQ-009 symbol_i  input  REC_W  record {num[NUM_WIDTH], freq[FREQ_WIDTH], len[LEN_WIDTH]}, MSB first; valid every cycle from start through end inclusive.
REQ-010 code_req_i  input  1  lookup request.
REQ-011 code_sym_i  input  DATA_WIDTH  symbol to look up.
REQ-012 code_valid_o  output  1  lookup result valid (one-cycle pulse).
REQ-013 code_o  output  MAX_LEN  canonical codeword, right-aligned (LSB = last bit sent).
REQ-014 code_len_o  output  LEN_WIDTH  codeword length; 0 = symbol unused.
REQ-015 ready_o  output  1  code table valid, lookups accepted.
REQ-016 busy_o  output  1  high in LOAD, COUNT, BASE, ASSIGN.
REQ-017 err_o  output  1  sticky error flag.

Function
REQ-018 SHALL implement states IDLE, LOAD, COUNT, BASE, ASSIGN, READY.
REQ-019 IDLE/READY: sym_start_i high -> clear length table, bl_count, code table and err_o; store record; go LOAD (or COUNT if sym_end_i also high).
REQ-020 LOAD: store each cycle's record at index num[DATA_WIDTH-1:0] (duplicates: last write wins); sym_end_i -> store, go COUNT.
REQ-021 Record with len > MAX_LEN SHALL set err_o and be stored as len 0.
REQ-022 More than DATA_SIZE records before sym_end_i SHALL set err_o; excess records ignored; indices never written keep len 0.
REQ-023 sym_start_i in LOAD, COUNT, BASE or ASSIGN SHALL set err_o and be otherwise ignored.
REQ-024 COUNT: one symbol per cycle, index 0..DATA_SIZE-1; if len != 0 increment bl_count[len]; exactly DATA_SIZE cycles.
REQ-025 BASE: one length per cycle, L = 1..MAX_LEN; code = (code + bl_count[L-1]) << 1 with bl_count[0] = 0; next_code[L] = code; exactly MAX_LEN cycles; arithmetic MAX_LEN+1 bits wide.
REQ-026 If next_code[L] + bl_count[L] > 2^L for any L (oversubscribed set), SHALL set err_o; table still built.
REQ-027 ASSIGN: index 0..DATA_SIZE-1, one per cycle; if len != 0: code[i] = next_code[len], then increment next_code[len]; exactly DATA_SIZE cycles, then READY.
REQ-028 ready_o SHALL rise 2*DATA_SIZE+MAX_LEN clock edges after the edge that samples sym_end_i.
REQ-029 READY: code_req_i sampled high -> next cycle code_valid_o = 1, code_o/code_len_o = entry of code_sym_i; back-to-back requests, one per cycle.
REQ-030 code_req_i outside READY SHALL be ignored; code_valid_o = 0, code_o = 0, code_len_o = 0 whenever no valid result.
REQ-031 READY with code_req_i and sym_start_i high in the same cycle: request served from the old table, then restart.

Reset
REQ-032 rst high, at any time including mid-stream or mid-ASSIGN: state IDLE, all counters and tables cleared, all outputs 0, within the same cycle without waiting for clk.
REQ-033 After rst falls, first action SHALL be a sym_start_i accepted in IDLE.

Verification (DATA_WIDTH=2, MAX_LEN=4)
REQ-034 Stream lens {1,2,3,3} for symbols 0..3 -> ready_o after 12 edges; lookups give 0/1, 10/2, 110/3, 111/3; err_o = 0.
REQ-035 Stream in order sym3 len1, sym0 len2, sym2 len2, sym1 len0 -> codes sym3=0/1, sym0=10/2, sym2=11/2, sym1=0/0.
REQ-036 Record len 5 for sym2, others {1,2,0,2} -> err_o = 1 at edge after that record; sym2 returns 0/0; ready_o still rises.
REQ-037 rst pulsed during ASSIGN -> ready_o, busy_o, code_valid_o immediately 0; new stream afterwards builds correct table.
REQ-038 In READY, request sym1 while sym_start_i asserts new stream -> code_valid_o with old entry, then busy_o = 1, ready_o = 0.
REQ-039 Lens {1,1,1,0} (oversubscribed) -> err_o = 1 by end of BASE; ready_o still rises.

Source files
------------

// File: rtl/huffman_canon.sv
// Canonical Huffman code builder: loads a (symbol, length) stream, counts lengths,
// derives first codes per length, assigns codewords, then serves per-symbol lookups.
module huffman_canon #(
  parameter int DATA_WIDTH = 8,
  parameter int FREQ_WIDTH = 8,
  parameter int MAX_LEN    = 16,
  localparam int NUM_WIDTH = DATA_WIDTH + 1,
  localparam int LEN_WIDTH = NUM_WIDTH,
  localparam int REC_W     = NUM_WIDTH + FREQ_WIDTH + LEN_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sym_start_i,
  input  logic                  sym_end_i,
  input  logic [REC_W-1:0]      symbol_i,
  input  logic                  code_req_i,
  input  logic [DATA_WIDTH-1:0] code_sym_i,
  output logic                  code_valid_o,
  output logic [MAX_LEN-1:0]    code_o,
  output logic [LEN_WIDTH-1:0]  code_len_o,
  output logic                  ready_o,
  output logic                  busy_o,
  output logic                  err_o
);

  localparam int DATA_SIZE = 1 << DATA_WIDTH;
  localparam int LVL_W     = $clog2(MAX_LEN + 1);
  localparam int CW        = MAX_LEN + 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_COUNT, S_BASE, S_ASSIGN, S_READY} state_t;

  state_t                state_q, state_d;
  logic [LEN_WIDTH-1:0]  len_tab_q  [DATA_SIZE];
  logic [MAX_LEN-1:0]    code_tab_q [DATA_SIZE];
  logic [NUM_WIDTH-1:0]  bl_count_q [MAX_LEN+1];
  logic [CW-1:0]         next_code_q[MAX_LEN+1];
  logic [CW-1:0]         code_acc_q, code_acc_d;
  logic [DATA_WIDTH-1:0] idx_q, idx_d;
  logic [LVL_W-1:0]      lvl_q, lvl_d;
  logic [NUM_WIDTH-1:0]  rec_cnt_q, rec_cnt_d;
  logic                  err_q, err_d;
  logic                  code_valid_q;
  logic [MAX_LEN-1:0]    code_out_q;
  logic [LEN_WIDTH-1:0]  code_len_q;

  logic [NUM_WIDTH-1:0]  rec_num;
  logic [LEN_WIDTH-1:0]  rec_len;
  logic [DATA_WIDTH-1:0] rec_idx;
  logic                  rec_len_bad;
  logic [LEN_WIDTH-1:0]  rec_store_len;
  logic                  rec_full;
  logic [LEN_WIDTH-1:0]  cur_len;
  logic [LVL_W-1:0]      cur_lvl;
  logic [CW-1:0]         base_code;
  logic                  lookup_hit;
  logic                  unused_bits;

  assign rec_num       = symbol_i[REC_W-1 -: NUM_WIDTH];
  assign rec_len       = symbol_i[LEN_WIDTH-1:0];
  assign rec_idx       = rec_num[DATA_WIDTH-1:0];
  assign rec_len_bad   = 32'(rec_len) > 32'(MAX_LEN);
  assign rec_store_len = rec_len_bad ? '0 : rec_len;
  assign rec_full      = (rec_cnt_q == NUM_WIDTH'(DATA_SIZE));
  assign cur_len       = len_tab_q[idx_q];
  assign cur_lvl       = LVL_W'(cur_len);
  assign lookup_hit    = (state_q == S_READY) && code_req_i;
  assign unused_bits   = ^{symbol_i[LEN_WIDTH +: FREQ_WIDTH], rec_num[DATA_WIDTH]};

  assign ready_o      = (state_q == S_READY);
  assign busy_o       = (state_q == S_LOAD) || (state_q == S_COUNT) ||
                        (state_q == S_BASE) || (state_q == S_ASSIGN);
  assign err_o        = err_q;
  assign code_valid_o = code_valid_q;
  assign code_o       = code_out_q;
  assign code_len_o   = code_len_q;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    lvl_d      = lvl_q;
    rec_cnt_d  = rec_cnt_q;
    err_d      = err_q;
    code_acc_d = code_acc_q;
    base_code  = '0;
    case (state_q)
      S_IDLE, S_READY: begin
        if (sym_start_i) begin
          state_d    = sym_end_i ? S_COUNT : S_LOAD;
          err_d      = rec_len_bad;
          rec_cnt_d  = NUM_WIDTH'(1);
          idx_d      = '0;
          lvl_d      = LVL_W'(1);
          code_acc_d = '0;
        end
      end
      S_LOAD: begin
        if (sym_start_i) err_d = 1'b1;
        // Records beyond the table size are dropped but flagged.
        if (rec_full) err_d = 1'b1;
        else begin
          rec_cnt_d = rec_cnt_q + 1'b1;
          if (rec_len_bad) err_d = 1'b1;
        end
        if (sym_end_i) state_d = S_COUNT;
      end
      S_COUNT: begin
        if (sym_start_i) err_d = 1'b1;
        idx_d = idx_q + 1'b1;
        if (idx_q == DATA_WIDTH'(DATA_SIZE - 1)) begin
          state_d    = S_BASE;
          lvl_d      = LVL_W'(1);
          code_acc_d = '0;
        end
      end
      S_BASE: begin
        if (sym_start_i) err_d = 1'b1;
        base_code  = (code_acc_q + CW'(bl_count_q[lvl_q - 1'b1])) << 1;
        code_acc_d = base_code;
        // More codes of this length than the length can hold: oversubscribed set.
        if ((32'(base_code) + 32'(bl_count_q[lvl_q])) > (32'd1 << lvl_q)) err_d = 1'b1;
        lvl_d = lvl_q + 1'b1;
        if (lvl_q == LVL_W'(MAX_LEN)) begin
          state_d = S_ASSIGN;
          idx_d   = '0;
        end
      end
      S_ASSIGN: begin
        if (sym_start_i) err_d = 1'b1;
        idx_d = idx_q + 1'b1;
        if (idx_q == DATA_WIDTH'(DATA_SIZE - 1)) state_d = S_READY;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      lvl_q      <= '0;
      rec_cnt_q  <= '0;
      err_q      <= 1'b0;
      code_acc_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      lvl_q      <= lvl_d;
      rec_cnt_q  <= rec_cnt_d;
      err_q      <= err_d;
      code_acc_q <= code_acc_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DATA_SIZE; i++) begin
        len_tab_q[i]  <= '0;
        code_tab_q[i] <= '0;
      end
      for (int l = 0; l <= MAX_LEN; l++) begin
        bl_count_q[l]  <= '0;
        next_code_q[l] <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE, S_READY: begin
          if (sym_start_i) begin
            for (int i = 0; i < DATA_SIZE; i++) begin
              len_tab_q[i]  <= '0;
              code_tab_q[i] <= '0;
            end
            for (int l = 0; l <= MAX_LEN; l++) begin
              bl_count_q[l]  <= '0;
              next_code_q[l] <= '0;
            end
            len_tab_q[rec_idx] <= rec_store_len;
          end
        end
        S_LOAD: begin
          if (!rec_full) len_tab_q[rec_idx] <= rec_store_len;
        end
        S_COUNT: begin
          if (cur_len != '0) bl_count_q[cur_lvl] <= bl_count_q[cur_lvl] + 1'b1;
        end
        S_BASE: begin
          next_code_q[lvl_q] <= base_code;
        end
        S_ASSIGN: begin
          if (cur_len != '0) begin
            code_tab_q[idx_q]    <= next_code_q[cur_lvl][MAX_LEN-1:0];
            next_code_q[cur_lvl] <= next_code_q[cur_lvl] + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Lookups read the table as it stood before this edge, so a restart in the
  // same cycle still returns the old entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_valid_q <= 1'b0;
      code_out_q   <= '0;
      code_len_q   <= '0;
    end else begin
      code_valid_q <= lookup_hit;
      code_out_q   <= lookup_hit ? code_tab_q[code_sym_i] : '0;
      code_len_q   <= lookup_hit ? len_tab_q[code_sym_i] : '0;
    end
  end

endmodule

// File: tb/tb_huffman_canon.sv
// Directed bench for huffman_canon at DATA_WIDTH=2, MAX_LEN=4 with a lookup scoreboard.
module tb_huffman_canon;

  localparam int DW   = 2;
  localparam int FW   = 8;
  localparam int MAXL = 4;
  localparam int NW   = DW + 1;
  localparam int LW   = NW;
  localparam int RW   = NW + FW + LW;
  localparam int NSYM = 1 << DW;
  localparam int LAT  = 2 * NSYM + MAXL;

  logic            clk;
  logic            rst;
  logic            sym_start_i;
  logic            sym_end_i;
  logic [RW-1:0]   symbol_i;
  logic            code_req_i;
  logic [DW-1:0]   code_sym_i;
  logic            code_valid_o;
  logic [MAXL-1:0] code_o;
  logic [LW-1:0]   code_len_o;
  logic            ready_o;
  logic            busy_o;
  logic            err_o;

  int n_assert = 0;
  int n_fail   = 0;

  logic [LW+MAXL-1:0] exp_q[$];

  int m_len  [NSYM];
  int m_code [NSYM];
  int m_cnt;
  bit m_err;

  huffman_canon #(.DATA_WIDTH(DW), .FREQ_WIDTH(FW), .MAX_LEN(MAXL)) dut (
    .clk          (clk),
    .rst          (rst),
    .sym_start_i  (sym_start_i),
    .sym_end_i    (sym_end_i),
    .symbol_i     (symbol_i),
    .code_req_i   (code_req_i),
    .code_sym_i   (code_sym_i),
    .code_valid_o (code_valid_o),
    .code_o       (code_o),
    .code_len_o   (code_len_o),
    .ready_o      (ready_o),
    .busy_o       (busy_o),
    .err_o        (err_o)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: canonical codes assigned in (length, symbol) order,
  // oversubscription judged by the Kraft sum.
  task automatic model_new();
    for (int s = 0; s < NSYM; s++) begin
      m_len[s]  = 0;
      m_code[s] = 0;
    end
    m_cnt = 0;
    m_err = 1'b0;
  endtask

  task automatic model_record(input int sym, input int len);
    if (m_cnt >= NSYM) m_err = 1'b1;
    else begin
      m_cnt++;
      if (len > MAXL) begin
        m_err      = 1'b1;
        m_len[sym] = 0;
      end else m_len[sym] = len;
    end
  endtask

  task automatic model_build();
    int  code;
    int  prev;
    bit  first;
    int  kraft;
    code  = 0;
    prev  = 0;
    first = 1'b1;
    kraft = 0;
    for (int s = 0; s < NSYM; s++) m_code[s] = 0;
    for (int l = 1; l <= MAXL; l++) begin
      for (int s = 0; s < NSYM; s++) begin
        if (m_len[s] == l) begin
          if (first) begin
            code  = 0;
            first = 1'b0;
          end else code = (code + 1) << (l - prev);
          prev      = l;
          m_code[s] = code & ((1 << MAXL) - 1);
          kraft    += 1 << (MAXL - l);
        end
      end
    end
    if (kraft > (1 << MAXL)) m_err = 1'b1;
  endtask

  // Driver tasks
  task automatic send_rec(input bit st, input bit en, input int sym, input int len);
    logic [NW-1:0] num;
    logic [FW-1:0] freq;
    logic [LW-1:0] ln;
    num  = NW'(sym);
    freq = FW'($urandom_range(0, 255));
    ln   = LW'(len);
    @(posedge clk); #1;
    sym_start_i = st;
    sym_end_i   = en;
    symbol_i    = {num, freq, ln};
    if (st) model_new();
    model_record(sym, len);
  endtask

  task automatic end_stream();
    @(posedge clk); #1;
    sym_start_i = 1'b0;
    sym_end_i   = 1'b0;
    symbol_i    = '0;
    model_build();
  endtask

  // Exact ready latency; a stray request while busy must be ignored.
  task automatic run_to_ready(input string tag);
    for (int k = 1; k <= LAT; k++) begin
      @(posedge clk); #1;
      code_req_i = (k == 3);
      code_sym_i = DW'(k);
      if (k == 1) check({tag, "_busy"}, busy_o, 1);
      if (k == 2 * NSYM) check({tag, "_err_base"}, err_o, m_err);
      if (k == LAT - 1) check({tag, "_early"}, ready_o, 0);
    end
    code_req_i = 1'b0;
    check({tag, "_ready"}, ready_o, 1);
    check({tag, "_idle"}, busy_o, 0);
    check({tag, "_err"}, err_o, m_err);
  endtask

  task automatic lookup_all();
    for (int s = 0; s < NSYM; s++) begin
      @(posedge clk); #1;
      code_req_i = 1'b1;
      code_sym_i = DW'(s);
      exp_q.push_back({LW'(m_len[s]), MAXL'(m_code[s])});
    end
    @(posedge clk); #1;
    code_req_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("drain", exp_q.size(), 0);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (code_valid_o) begin
        if (exp_q.size() == 0) check("unexpected_valid", code_valid_o, 0);
        else check("lookup", {code_len_o, code_o}, exp_q.pop_front());
      end else begin
        check("no_result_zero", {code_len_o, code_o}, 0);
      end
    end
  end

  initial begin
    rst         = 1'b1;
    sym_start_i = 1'b0;
    sym_end_i   = 1'b0;
    symbol_i    = '0;
    code_req_i  = 1'b0;
    code_sym_i  = '0;
    model_new();
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", ready_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_err", err_o, 0);
    check("rst_valid", code_valid_o, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Lengths {1,2,3,3}
    send_rec(1, 0, 0, 1);
    send_rec(0, 0, 1, 2);
    send_rec(0, 0, 2, 3);
    send_rec(0, 1, 3, 3);
    end_stream();
    run_to_ready("t1");
    lookup_all();

    // Out-of-order stream, restart straight from READY
    send_rec(1, 0, 3, 1);
    send_rec(0, 0, 0, 2);
    send_rec(0, 0, 2, 2);
    send_rec(0, 1, 1, 0);
    end_stream();
    run_to_ready("t2");
    lookup_all();

    // Too many records: fifth is dropped
    send_rec(1, 0, 0, 1);
    send_rec(0, 0, 1, 2);
    send_rec(0, 0, 2, 3);
    send_rec(0, 0, 3, 3);
    send_rec(0, 1, 0, 4);
    end_stream();
    check("excess_err", err_o, 1);
    run_to_ready("t_excess");
    lookup_all();

    // Over-long length on sym2
    send_rec(1, 0, 0, 1);
    send_rec(0, 0, 1, 2);
    send_rec(0, 0, 3, 2);
    check("badlen_err_before", err_o, 0);
    send_rec(0, 1, 2, 5);
    end_stream();
    check("badlen_err_after", err_o, 1);
    run_to_ready("t_badlen");
    lookup_all();

    // Oversubscribed {1,1,1,0}
    send_rec(1, 0, 0, 1);
    send_rec(0, 0, 1, 1);
    send_rec(0, 0, 2, 1);
    send_rec(0, 1, 3, 0);
    end_stream();
    run_to_ready("t_oversub");
    lookup_all();

    // Request and restart in the same READY cycle
    @(posedge clk); #1;
    code_req_i = 1'b1;
    code_sym_i = DW'(1);
    exp_q.push_back({LW'(m_len[1]), MAXL'(m_code[1])});
    model_new();
    sym_start_i = 1'b1;
    symbol_i    = {NW'(0), FW'($urandom_range(0, 255)), LW'(1)};
    model_record(0, 1);
    @(posedge clk); #1;
    code_req_i = 1'b0;
    check("restart_busy", busy_o, 1);
    check("restart_ready", ready_o, 0);
    sym_start_i = 1'b0;
    sym_end_i   = 1'b1;
    symbol_i    = {NW'(1), FW'($urandom_range(0, 255)), LW'(1)};
    model_record(1, 1);
    end_stream();
    run_to_ready("t_restart");
    lookup_all();

    // Reset in the middle of ASSIGN
    send_rec(1, 0, 0, 2);
    send_rec(0, 0, 1, 2);
    send_rec(0, 0, 2, 2);
    send_rec(0, 1, 3, 2);
    end_stream();
    repeat (2 * NSYM + MAXL - 2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("arst_ready", ready_o, 0);
    check("arst_busy", busy_o, 0);
    check("arst_valid", code_valid_o, 0);
    check("arst_err", err_o, 0);
    check("arst_code", {code_len_o, code_o}, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    send_rec(1, 0, 3, 1);
    send_rec(0, 0, 2, 2);
    send_rec(0, 0, 0, 3);
    send_rec(0, 1, 1, 3);
    end_stream();
    run_to_ready("t_after_rst");
    lookup_all();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
